// File: rtl/aes_decrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_decrypt_iter
//
// Iterative AES-128 inverse cipher, one inverse round per clock.
// It takes a ciphertext and the round-0 cipher key, expands the key forward
// to round key 10, then walks the key schedule backwards while applying the
// inverse rounds. Byte 0 is bits [127:120] and the state is column-major,
// matching the encryption core this block sits beside.
//
// Parameters
//   CLEAR_ON_DONE  1: zero state, round key, plaintext and cached-key
//                     registers on the output handshake. 0: keep them.
//
// Optional feature (compile-time macro AES_DEC_KEY_CACHE_EN)
//   When defined, the last expanded round key is cached together with the
//   key that produced it. A job whose key matches the cached tag skips the
//   forward expansion, so its latency drops from 21 to 11 clocks.
//
// Ports
//   clk_i        rising-edge clock
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   ciphertext and key are valid
//   in_ready_o   block can accept a new job (IDLE only)
//   key_in_i     128-bit cipher key (round-0 key)
//   ct_in_i      128-bit ciphertext
//   out_valid_o  plaintext is valid and held stable
//   out_ready_i  downstream accepts the plaintext
//   pt_out_o     128-bit plaintext
//   busy_o       FSM is not in IDLE
// ---------------------------------------------------------------------------
module aes_decrypt_iter #(
   parameter bit CLEAR_ON_DONE = 1'b1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] key_in_i,
   input  logic [127:0] ct_in_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] pt_out_o,
   output logic         busy_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KEXP  = 3'd1,
      ARK0  = 3'd2,
      ROUND = 3'd3,
      FINAL = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t       state_q, state_d;
   logic [127:0] aesState_q, aesState_d;
   logic [127:0] roundKey_q, roundKey_d;
   logic [127:0] pt_q, pt_d;
   logic [3:0]   cnt_q, cnt_d;

`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] keyTag_q, keyTag_d;
   logic [127:0] rk10Cache_q, rk10Cache_d;
   logic         cacheVld_q, cacheVld_d;
`endif

   logic [127:0] fwdKey;
   logic [127:0] invKey;
   logic [127:0] invCore;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
   function automatic logic [7:0] gfInv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gfMul(x, x);
      x3   = gfMul(x2, x);
      x6   = gfMul(x3, x3);
      x12  = gfMul(x6, x6);
      x15  = gfMul(x12, x3);
      x30  = gfMul(x15, x15);
      x60  = gfMul(x30, x30);
      x120 = gfMul(x60, x60);
      x240 = gfMul(x120, x120);
      x252 = gfMul(x240, x12);
      return gfMul(x252, x2);
   endfunction

   // Forward S-box: field inverse followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gfInv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Inverse S-box: inverse affine transform followed by the field inverse.
   function automatic logic [7:0] invSbox(input logic [7:0] x);
      return gfInv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] subRotWord(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [127:0] fwdExpand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ subRotWord(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one forward expansion step: the newer words are recovered first,
   // then w0 is recovered from the restored w3.
   function automatic logic [127:0] invExpand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]  ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ subRotWord(w3) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   // InvShiftRows then InvSubBytes. Row r rotates right by r columns, so
   // output byte (r,c) comes from input byte (r,(c-r) mod 4).
   function automatic logic [127:0] invShiftSub(input logic [127:0] s);
      logic [127:0] o;
      int           r, c, src;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         r   = i % 4;
         c   = i / 4;
         src = r + 4 * ((c - r + 4) % 4);
         o[127 - 8*i -: 8] = invSbox(s[127 - 8*src -: 8]);
      end
      return o;
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09);
         o[119 - 32*c -: 8] = gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d);
         o[111 - 32*c -: 8] = gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b);
         o[103 - 32*c -: 8] = gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Shared datapath terms. The counter doubles as the rcon index: it counts
   // 1..10 during forward expansion, sits at 10 in ARK0 and counts 9..1 in
   // the inverse rounds, so one rcon lookup serves every state.
   always_comb begin
      fwdKey  = fwdExpand(roundKey_q, rcon(cnt_q));
      invKey  = invExpand(roundKey_q, rcon(cnt_q));
      invCore = invShiftSub(aesState_q);
   end

   // Next-state and datapath control. Inputs are only looked at in IDLE; a
   // cache hit jumps straight to ARK0 with the counter preset to 10 so the
   // first backward key step uses rcon[10] exactly as after a full KEXP.
   always_comb begin
      state_d    = state_q;
      aesState_d = aesState_q;
      roundKey_d = roundKey_q;
      pt_d       = pt_q;
      cnt_d      = cnt_q;
`ifdef AES_DEC_KEY_CACHE_EN
      keyTag_d    = keyTag_q;
      rk10Cache_d = rk10Cache_q;
      cacheVld_d  = cacheVld_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               aesState_d = ct_in_i;
`ifdef AES_DEC_KEY_CACHE_EN
               if (cacheVld_q && (key_in_i == keyTag_q)) begin
                  roundKey_d = rk10Cache_q;
                  cnt_d      = 4'd10;
                  state_d    = ARK0;
               end else begin
                  roundKey_d = key_in_i;
                  cnt_d      = 4'd1;
                  state_d    = KEXP;
                  keyTag_d   = key_in_i;
                  cacheVld_d = 1'b0;
               end
`else
               roundKey_d = key_in_i;
               cnt_d      = 4'd1;
               state_d    = KEXP;
`endif
            end
         end
         KEXP: begin
            roundKey_d = fwdKey;
            if (cnt_q == 4'd10) begin
               state_d = ARK0;
`ifdef AES_DEC_KEY_CACHE_EN
               rk10Cache_d = fwdKey;
               cacheVld_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ARK0: begin
            aesState_d = aesState_q ^ roundKey_q;
            roundKey_d = invKey;
            cnt_d      = 4'd9;
            state_d    = ROUND;
         end
         ROUND: begin
            aesState_d = invMixColumns(invCore ^ roundKey_q);
            roundKey_d = invKey;
            cnt_d      = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = FINAL;
         end
         FINAL: begin
            pt_d    = invCore ^ roundKey_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
               if (CLEAR_ON_DONE) begin
                  aesState_d = '0;
                  roundKey_d = '0;
                  pt_d       = '0;
`ifdef AES_DEC_KEY_CACHE_EN
                  keyTag_d    = '0;
                  rk10Cache_d = '0;
                  cacheVld_d  = 1'b0;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset is asynchronous so a mid-job abort
   // drops the outputs back to idle values without waiting for a clock.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         aesState_q <= '0;
         roundKey_q <= '0;
         pt_q       <= '0;
         cnt_q      <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
         keyTag_q    <= '0;
         rk10Cache_q <= '0;
         cacheVld_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         aesState_q <= aesState_d;
         roundKey_q <= roundKey_d;
         pt_q       <= pt_d;
         cnt_q      <= cnt_d;
`ifdef AES_DEC_KEY_CACHE_EN
         keyTag_q    <= keyTag_d;
         rk10Cache_q <= rk10Cache_d;
         cacheVld_q  <= cacheVld_d;
`endif
      end
   end

   // Handshake flags decode straight from the state register.
   always_comb begin
      in_ready_o  = (state_q == IDLE);
      out_valid_o = (state_q == DONE);
      busy_o      = (state_q != IDLE);
      pt_out_o    = pt_q;
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
module tb_aes_decrypt_iter;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_Z  = 128'h0;
   localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] PT_Z   = 128'h0;
   localparam int FULL_LAT = 21;
`ifdef AES_DEC_KEY_CACHE_EN
   localparam int HIT_LAT = 11;
`else
   localparam int HIT_LAT = 21;
`endif

   typedef struct {
      logic [127:0] pt;
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rstN;
   logic         inValid, inReady, outValid, outReady, busy;
   logic [127:0] keyIn, ctIn, ptOut;
   logic         kValid, kInReady, kOutValid, kOutReady, kBusy;
   logic [127:0] kPtOut;

   exp_t expQ[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   always #5 clk = ~clk;

   aes_decrypt_iter dut (
      .clk_i(clk), .rst_n_i(rstN), .in_valid_i(inValid), .in_ready_o(inReady),
      .key_in_i(keyIn), .ct_in_i(ctIn), .out_valid_o(outValid),
      .out_ready_i(outReady), .pt_out_o(ptOut), .busy_o(busy)
   );

   aes_decrypt_iter #(.CLEAR_ON_DONE(1'b0)) dutKeep (
      .clk_i(clk), .rst_n_i(rstN), .in_valid_i(kValid), .in_ready_o(kInReady),
      .key_in_i(keyIn), .ct_in_i(ctIn), .out_valid_o(kOutValid),
      .out_ready_i(kOutReady), .pt_out_o(kPtOut), .busy_o(kBusy)
   );

   // Offer a job until accepted, then push its expectation to the scoreboard
   // and scramble the data inputs so late latching would be noticed.
   task automatic applyStimulus(input bit useKeep, input logic [127:0] key,
                                input logic [127:0] ct, input logic [127:0] pt,
                                input int lat, output bit ok);
      exp_t e;
      ok = 1'b0;
      keyIn = key;
      ctIn  = ct;
      if (useKeep) kValid = 1'b1;
      else inValid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if ((useKeep ? kInReady : inReady) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         e.pt  = pt;
         e.lat = lat;
         expQ.push_back(e);
      end
      @(negedge clk);
      inValid = 1'b0;
      kValid  = 1'b0;
      keyIn   = {$urandom(), $urandom(), $urandom(), $urandom()};
      ctIn    = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   // Count rising edges until out_valid is seen (bounded).
   task automatic awaitOutput(input bit useKeep, output int lat, output bit seen);
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         lat++;
         #1;
         if ((useKeep ? kOutValid : outValid) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      inValid = 1'b0; outReady = 1'b0; kValid = 1'b0; kOutReady = 1'b0;
      keyIn = '0; ctIn = '0;
      repeat (3) @(negedge clk);
      testsRun++;
      if ({inReady, outValid, busy} !== 3'b100) begin
         testsFailed++;
         $display("[TB] FAIL reset_flags: got ready/valid/busy=%b expected 100", {inReady, outValid, busy});
      end
      testsRun++;
      if (ptOut !== 128'h0) begin
         testsFailed++;
         $display("[TB] FAIL reset_pt: got %h expected 0", ptOut);
      end
      rstN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fips_c1();
      bit ok, seen;
      int lat;
      exp_t e;
      outReady = 1'b0;
      applyStimulus(1'b0, KEY_C1, CT_C1, PT_C1, FULL_LAT, ok);
      testsRun++;
      if (!ok) begin
         testsFailed++;
         $display("[TB] FAIL c1_accept: got no accept expected accept");
         return;
      end
      testsRun++;
      if (busy !== 1'b1 || inReady !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL c1_busy: got busy=%b ready=%b expected 1/0", busy, inReady);
      end
      awaitOutput(1'b0, lat, seen);
      e = expQ.pop_front();
      testsRun++;
      if (!seen || lat !== e.lat) begin
         testsFailed++;
         $display("[TB] FAIL c1_latency: got %0d (seen=%0b) expected %0d", lat, seen, e.lat);
      end
      testsRun++;
      if (ptOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL c1_pt: got %h expected %h", ptOut, e.pt);
      end
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      testsRun++;
      if ({inReady, outValid, busy} !== 3'b100 || ptOut !== 128'h0) begin
         testsFailed++;
         $display("[TB] FAIL c1_handshake: got rdy/vld/busy=%b pt=%h expected 100 and 0",
                  {inReady, outValid, busy}, ptOut);
      end
   endtask

   task automatic test_app_b_stall();
      bit ok, seen, stallBad;
      int lat;
      exp_t e;
      outReady = 1'b0;
      applyStimulus(1'b0, KEY_B, CT_B, PT_B, FULL_LAT, ok);
      repeat (10) @(posedge clk);
      #1;
      testsRun++;
      if (dut.roundKey_q !== RK10_B) begin
         testsFailed++;
         $display("[TB] FAIL b_rk10: got %h expected %h", dut.roundKey_q, RK10_B);
      end
      awaitOutput(1'b0, lat, seen);
      lat += 10;
      e = expQ.pop_front();
      testsRun++;
      if (!ok || !seen || lat !== e.lat) begin
         testsFailed++;
         $display("[TB] FAIL b_latency: got %0d (seen=%0b) expected %0d", lat, seen, e.lat);
      end
      testsRun++;
      if (ptOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL b_pt: got %h expected %h", ptOut, e.pt);
      end
      stallBad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ptOut !== e.pt || inReady !== 1'b0 || outValid !== 1'b1) stallBad = 1'b1;
         inValid = i[0];
         keyIn = KEY_C1;
         ctIn  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      inValid = 1'b0;
      testsRun++;
      if (stallBad) begin
         testsFailed++;
         $display("[TB] FAIL stall_hold: got output change during stall expected stable pt %h", e.pt);
      end
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      testsRun++;
      if ({inReady, outValid, busy} !== 3'b100) begin
         testsFailed++;
         $display("[TB] FAIL stall_release: got rdy/vld/busy=%b expected 100", {inReady, outValid, busy});
      end
   endtask

   task automatic test_back_to_back();
      bit ok, seen;
      int lat;
      exp_t e;
      outReady = 1'b1;
      applyStimulus(1'b0, KEY_Z, CT_Z, PT_Z, FULL_LAT, ok);
      awaitOutput(1'b0, lat, seen);
      e = expQ.pop_front();
      testsRun++;
      if (!ok || !seen || lat !== e.lat || ptOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL b2b_zero: got lat=%0d pt=%h expected lat=%0d pt=%h", lat, ptOut, e.lat, e.pt);
      end
      applyStimulus(1'b0, KEY_B, CT_B, PT_B, FULL_LAT, ok);
      awaitOutput(1'b0, lat, seen);
      e = expQ.pop_front();
      testsRun++;
      if (!ok || !seen || lat !== e.lat || ptOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL b2b_appb: got lat=%0d pt=%h expected lat=%0d pt=%h", lat, ptOut, e.lat, e.pt);
      end
      @(posedge clk);
      #1;
      outReady = 1'b0;
      testsRun++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL b2b_idle: got vld=%b rdy=%b expected 0/1", outValid, inReady);
      end
   endtask

   task automatic test_abort();
      bit ok, seen;
      int lat;
      exp_t e;
      outReady = 1'b0;
      applyStimulus(1'b0, KEY_B, CT_B, PT_B, FULL_LAT, ok);
      e = expQ.pop_front();
      repeat (15) @(posedge clk);
      #2;
      rstN = 1'b0;
      #1;
      testsRun++;
      if ({inReady, outValid, busy} !== 3'b100 || ptOut !== 128'h0) begin
         testsFailed++;
         $display("[TB] FAIL abort_outputs: got rdy/vld/busy=%b pt=%h expected 100 and 0",
                  {inReady, outValid, busy}, ptOut);
      end
      @(negedge clk);
      rstN = 1'b1;
      @(negedge clk);
      applyStimulus(1'b0, KEY_C1, CT_C1, PT_C1, FULL_LAT, ok);
      awaitOutput(1'b0, lat, seen);
      e = expQ.pop_front();
      testsRun++;
      if (!ok || !seen || lat !== e.lat || ptOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL abort_rerun: got lat=%0d pt=%h expected lat=%0d pt=%h", lat, ptOut, e.lat, e.pt);
      end
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
   endtask

   task automatic test_keep_cache();
      bit ok, seen;
      int lat;
      exp_t e;
      kOutReady = 1'b1;
      applyStimulus(1'b1, KEY_B, CT_B, PT_B, FULL_LAT, ok);
      awaitOutput(1'b1, lat, seen);
      e = expQ.pop_front();
      testsRun++;
      if (!ok || !seen || lat !== e.lat || kPtOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL keep_job1: got lat=%0d pt=%h expected lat=%0d pt=%h", lat, kPtOut, e.lat, e.pt);
      end
      applyStimulus(1'b1, KEY_B, CT_B, PT_B, HIT_LAT, ok);
      awaitOutput(1'b1, lat, seen);
      e = expQ.pop_front();
      testsRun++;
      if (!ok || !seen || lat !== e.lat || kPtOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL keep_job2: got lat=%0d pt=%h expected lat=%0d pt=%h", lat, kPtOut, e.lat, e.pt);
      end
      applyStimulus(1'b1, KEY_C1, CT_C1, PT_C1, FULL_LAT, ok);
      awaitOutput(1'b1, lat, seen);
      e = expQ.pop_front();
      testsRun++;
      if (!ok || !seen || lat !== e.lat || kPtOut !== e.pt) begin
         testsFailed++;
         $display("[TB] FAIL keep_job3: got lat=%0d pt=%h expected lat=%0d pt=%h", lat, kPtOut, e.lat, e.pt);
      end
      @(posedge clk);
      #1;
      kOutReady = 1'b0;
      testsRun++;
      if (kOutValid !== 1'b0 || kPtOut !== PT_C1) begin
         testsFailed++;
         $display("[TB] FAIL keep_hold: got vld=%b pt=%h expected 0 and %h", kOutValid, kPtOut, PT_C1);
      end
   endtask

   initial begin
      test_reset();
      test_fips_c1();
      test_app_b_stall();
      test_back_to_back();
      test_abort();
      test_keep_cache();
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
